// File: rtl/tft_rd_sched_pkg.sv
// Shared types and constants for the TFT read-side scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: panel geometry, RGB565 pixel type, scheduler FSM encoding, counter-width helper.
package tft_rd_sched_pkg;

    localparam int TFT_H_VALID = 480;
    localparam int TFT_V_VALID = 272;
    localparam int RGB565_W    = 16;

    typedef logic [RGB565_W-1:0] rgb565_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_INIT = 2'd1,
        S_PRIME     = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    // Width for a counter that spans 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tft_rd_sched_if.sv
// Bundle between the read scheduler, the SDRAM read FIFO and the tft_disp timing block.
// Latency: n/a (wires only).
// Backpressure: none; the FIFO empty flag is the only flow-control signal.
// master: scheduler side (drives pops, pixel data, control pulses and status).
// slave : environment side (drives init level, pixel requests, FIFO flags and data).
interface tft_rd_sched_if
    import tft_rd_sched_pkg::*;
#(
    parameter int UF_CNT_W = 8
);
    // Environment -> scheduler
    logic                sdram_init_done;
    logic                read_data_req;
    logic                fifo_empty;
    rgb565_t             fifo_q;

    // Scheduler -> environment
    logic                fifo_rd_en;
    rgb565_t             pix_data;
    logic                rd_enable;
    logic                rd_restart;
    logic                fifo_flush;
    logic                disp_rst_n;
    logic                bl;
    logic                frame_done;
    logic                underflow;
    logic [UF_CNT_W-1:0] uf_cnt;

    modport master (
        input  sdram_init_done, read_data_req, fifo_empty, fifo_q,
        output fifo_rd_en, pix_data, rd_enable, rd_restart, fifo_flush,
               disp_rst_n, bl, frame_done, underflow, uf_cnt
    );

    modport slave (
        output sdram_init_done, read_data_req, fifo_empty, fifo_q,
        input  fifo_rd_en, pix_data, rd_enable, rd_restart, fifo_flush,
               disp_rst_n, bl, frame_done, underflow, uf_cnt
    );

endinterface

// File: rtl/tft_rd_sched.sv
// Read-side scheduler: display bring-up sequencing, request-to-pop conversion, frame tracking.
// Latency: pop is combinational with the request; pixel data one cycle after the request.
// Backpressure: none; an empty FIFO on a request substitutes FILL_COLOR and counts an underflow.
// Ports: i_clk_9m pixel clock, i_sysrst_n async active-low reset,
//        bus (master) FIFO pop/data, pixel output, SDRAM read enable/restart/flush,
//        display reset, backlight, frame-done pulse and underflow status.
module tft_rd_sched
    import tft_rd_sched_pkg::*;
#(
    parameter int      H_VALID    = TFT_H_VALID,
    parameter int      V_VALID    = TFT_V_VALID,
    parameter int      BL_DLY_CYC = 9000,
    parameter rgb565_t FILL_COLOR = 16'h0000,
    parameter int      UF_CNT_W   = 8
) (
    input  logic           i_clk_9m,
    input  logic           i_sysrst_n,
    tft_rd_sched_if.master bus
);

    localparam int PX_W = cnt_w(H_VALID);
    localparam int LN_W = cnt_w(V_VALID);
    localparam int BL_W = cnt_w(BL_DLY_CYC);

    localparam logic [PX_W-1:0]     PX_LAST = PX_W'(H_VALID - 1);
    localparam logic [LN_W-1:0]     LN_LAST = LN_W'(V_VALID - 1);
    localparam logic [BL_W-1:0]     BL_LAST = BL_W'(BL_DLY_CYC - 1);
    localparam logic [UF_CNT_W-1:0] UF_MAX  = '1;

    state_t              state;
    state_t              state_nxt;
    logic                rd_enable_c;

    logic [PX_W-1:0]     px_cnt;
    logic [LN_W-1:0]     ln_cnt;
    logic [BL_W-1:0]     bl_cnt;
    logic                bl_q;
    logic                disp_rst_n_q;
    logic                hit_q;
    logic                uf_frame;
    logic                underflow_q;
    logic [UF_CNT_W-1:0] uf_cnt_q;
    logic                frame_done_q;
    logic                rd_restart_q;
    logic                fifo_flush_q;

    logic                in_run;
    logic                run_ok;
    logic                pop;
    logic                uf_ev;
    logic                slot;
    logic                frame_end;

    // ------------------------------------------------------------------
    // Bring-up FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk_9m or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rd_enable_c = 1'b0;
        unique case (state)
            S_IDLE: begin
                state_nxt = S_WAIT_INIT;
            end
            S_WAIT_INIT: begin
                if (bus.sdram_init_done) begin
                    state_nxt = S_PRIME;
                end
            end
            S_PRIME: begin
                rd_enable_c = 1'b1;
                if (!bus.sdram_init_done) begin
                    state_nxt = S_WAIT_INIT;
                end else if (!bus.fifo_empty) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                rd_enable_c = 1'b1;
                if (!bus.sdram_init_done) begin
                    state_nxt = S_WAIT_INIT;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign in_run = (state == S_RUN);
    // Running and staying in RUN next cycle; losing init_done clears all
    // per-frame tracking, so nothing frame-related is launched that cycle.
    assign run_ok    = in_run & bus.sdram_init_done;
    assign pop       = in_run & bus.read_data_req & ~bus.fifo_empty;
    assign uf_ev     = in_run & bus.read_data_req &  bus.fifo_empty;
    // A request consumes a pixel slot whether or not the FIFO had data.
    assign slot      = run_ok & bus.read_data_req;
    assign frame_end = slot & (px_cnt == PX_LAST) & (ln_cnt == LN_LAST);

    // ------------------------------------------------------------------
    // Display release, backlight delay, position tracking
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk_9m or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            disp_rst_n_q <= 1'b0;
            bl_cnt       <= '0;
            bl_q         <= 1'b0;
            px_cnt       <= '0;
            ln_cnt       <= '0;
        end else begin
            // Registered: tft_disp leaves reset the cycle after RUN entry.
            disp_rst_n_q <= run_ok;

            // bl_cnt is 0 on the RUN entry cycle; backlight turns on the
            // cycle after it reaches its last value and then holds.
            if (!run_ok) begin
                bl_cnt <= '0;
                bl_q   <= 1'b0;
            end else if (bl_cnt == BL_LAST) begin
                bl_q   <= 1'b1;
            end else begin
                bl_cnt <= bl_cnt + 1'b1;
            end

            if (!run_ok) begin
                px_cnt <= '0;
                ln_cnt <= '0;
            end else if (bus.read_data_req) begin
                if (px_cnt == PX_LAST) begin
                    px_cnt <= '0;
                    ln_cnt <= (ln_cnt == LN_LAST) ? '0 : ln_cnt + 1'b1;
                end else begin
                    px_cnt <= px_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Data path, underflow accounting, frame-end pulses
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk_9m or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            hit_q        <= 1'b0;
            uf_frame     <= 1'b0;
            underflow_q  <= 1'b0;
            uf_cnt_q     <= '0;
            frame_done_q <= 1'b0;
            rd_restart_q <= 1'b0;
            fifo_flush_q <= 1'b0;
        end else begin
            hit_q <= pop;

            // Status survives an init_done drop; only reset clears it.
            if (uf_ev) begin
                underflow_q <= 1'b1;
                if (uf_cnt_q != UF_MAX) begin
                    uf_cnt_q <= uf_cnt_q + 1'b1;
                end
            end

            // An underflow on the last pixel still forces this frame's flush.
            frame_done_q <= frame_end;
            rd_restart_q <= frame_end;
            fifo_flush_q <= frame_end & (uf_frame | uf_ev);

            if (!run_ok || frame_end) begin
                uf_frame <= 1'b0;
            end else if (uf_ev) begin
                uf_frame <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.fifo_rd_en = pop;
    assign bus.pix_data   = hit_q ? bus.fifo_q : FILL_COLOR;
    assign bus.rd_enable  = rd_enable_c;
    assign bus.rd_restart = rd_restart_q;
    assign bus.fifo_flush = fifo_flush_q;
    assign bus.disp_rst_n = disp_rst_n_q;
    assign bus.bl         = bl_q;
    assign bus.frame_done = frame_done_q;
    assign bus.underflow  = underflow_q;
    assign bus.uf_cnt     = uf_cnt_q;

endmodule
